// File: rtl/addsub_cmd_issuer.sv
// addsub_cmd_issuer
//   Command front end for adder_sub. Buffers add/sub commands in a small
//   FIFO and issues them one at a time: operands, ctrl and a one-cycle
//   enable pulse go to adder_sub. Its registered data_out is captured two
//   cycles later and returned with the opcode on a valid/ready result port.
//
//   state | meaning
//   IDLE  | nothing outstanding, waiting for a queued command and issue_en
//   EXEC  | enable high this cycle, adder_sub registers at the closing edge
//   CAPT  | addsub_data_out holds the result, captured at the closing edge
//   RESP  | result held on res_* until res_ready
//
// Ports
//   clk, rst                         clock, async active-high reset
//   in_valid/in_ready/in_a/in_b/in_op command input (in_op 1 = add, 0 = sub)
//   issue_en                          gates popping of new commands
//   data_in_1/data_in_2/enable/ctrl   registered drive to adder_sub
//   addsub_data_out                   adder_sub data_out
//   res_valid/res_ready/res_data/res_op result output
//   fifo_count                        command FIFO occupancy
module addsub_cmd_issuer #(
  parameter int DATA_WIDTH = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DATA_WIDTH-1:0]         in_a,
  input  logic [DATA_WIDTH-1:0]         in_b,
  input  logic                          in_op,
  input  logic                          issue_en,
  output logic [DATA_WIDTH-1:0]         data_in_1,
  output logic [DATA_WIDTH-1:0]         data_in_2,
  output logic                          enable,
  output logic                          ctrl,
  input  logic [DATA_WIDTH:0]           addsub_data_out,
  output logic                          res_valid,
  input  logic                          res_ready,
  output logic [DATA_WIDTH:0]           res_data,
  output logic                          res_op,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = 2 * DATA_WIDTH + 1;

  typedef enum logic [1:0] {IDLE, EXEC, CAPT, RESP} state_t;

  state_t          state_q, state_d;
  logic [EW-1:0]   mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic            full, empty, push, pop;
  logic [EW-1:0]   head;

  assign full     = (fifo_count == CW'(FIFO_DEPTH));
  assign empty    = (fifo_count == '0);
  assign in_ready = !full;
  assign push     = in_valid && in_ready;
  assign head     = mem[rd_ptr];

  // FIFO entry layout: {op, b, a}
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {in_op, in_b, in_a};
  end

  // Pointers wrap naturally since FIFO_DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      fifo_count <= fifo_count + CW'(1);
      else if (pop && !push) fifo_count <= fifo_count - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty && issue_en) begin
          pop     = 1'b1;
          state_d = EXEC;
        end
      end
      EXEC: state_d = CAPT;
      CAPT: state_d = RESP;
      RESP: begin
        if (res_ready) begin
          if (!empty && issue_en) begin
            pop     = 1'b1;
            state_d = EXEC;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // enable follows pop by one edge, so it is high only during EXEC.
  // ctrl keeps the issued opcode, which is what res_op reports.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      enable    <= 1'b0;
      ctrl      <= 1'b0;
      data_in_1 <= '0;
      data_in_2 <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_op    <= 1'b0;
    end else begin
      enable <= pop;
      if (pop) {ctrl, data_in_2, data_in_1} <= head;
      if (state_q == CAPT) begin
        res_data  <= addsub_data_out;
        res_op    <= ctrl;
        res_valid <= 1'b1;
      end else if (state_q == RESP && res_ready) begin
        res_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_addsub_cmd_issuer.sv
module tb_addsub_cmd_issuer;

  localparam int DW = 4;
  localparam int FD = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid, in_ready;
  logic [DW-1:0]   in_a, in_b;
  logic            in_op, issue_en;
  logic [DW-1:0]   data_in_1, data_in_2;
  logic            enable, ctrl;
  logic [DW:0]     as_out;
  logic            res_valid, res_ready;
  logic [DW:0]     res_data;
  logic            res_op;
  logic [2:0]      fifo_count;

  int n_vec  = 0;
  int n_fail = 0;
  int n_results = 0;
  logic [5:0] exp_q[$];
  bit prev_en = 1'b0;

  addsub_cmd_issuer #(.DATA_WIDTH(DW), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .issue_en(issue_en),
    .data_in_1(data_in_1), .data_in_2(data_in_2),
    .enable(enable), .ctrl(ctrl),
    .addsub_data_out(as_out),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_op(res_op),
    .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  // adder_sub stand-in: registers the result on the enable edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) as_out <= '0;
    else if (enable)
      as_out <= ctrl ? ({1'b0, data_in_1} + {1'b0, data_in_2})
                     : ({1'b0, data_in_1} - {1'b0, data_in_2});
  end

  function automatic logic [4:0] ref_result(input int a, input int b, input bit op);
    int r;
    r = op ? (a + b) : (a - b);
    return r[4:0];
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard: expected results in push order; invariants on enable.
  always @(posedge clk) begin
    if (rst) begin
      prev_en = 1'b0;
    end else begin
      if (in_valid && in_ready)
        exp_q.push_back({in_op, ref_result(int'(in_a), int'(in_b), in_op)});
      if (res_valid && res_ready) begin
        n_results++;
        if (exp_q.size() == 0) chk("unexpected_result", 16'd1, 16'd0);
        else chk("result", {10'd0, res_op, res_data}, {10'd0, exp_q.pop_front()});
      end
      if (enable) begin
        chk("enable_while_res_valid", {15'd0, res_valid}, 16'd0);
        chk("enable_single_cycle", {15'd0, prev_en}, 16'd0);
      end
      prev_en = enable;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_cmd(input logic [3:0] a, input logic [3:0] b, input logic op);
    bit acc = 1'b0;
    in_a = a; in_b = b; in_op = op; in_valid = 1'b1;
    for (int k = 0; k < 60 && !acc; k++) begin
      acc = in_ready;
      step();
    end
    in_valid = 1'b0;
    chk("push_accept", {15'd0, acc}, 16'd1);
  endtask

  task automatic wait_drain(input int budget);
    res_ready = 1'b1;
    for (int k = 0; k < budget && (exp_q.size() != 0 || res_valid); k++) step();
    chk("drain_queue", 16'(exp_q.size()), 16'd0);
    chk("drain_res_valid", {15'd0, res_valid}, 16'd0);
    res_ready = 1'b0;
  endtask

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       op;
    logic [4:0] res;
  } vec_t;

  vec_t tbl[8];

  initial begin
    int times[$];
    logic [4:0] held_data;
    logic       held_op;
    bit         seen;
    int         base;

    tbl[0] = '{4'd5,  4'd3,  1'b1, 5'b01000};
    tbl[1] = '{4'd3,  4'd5,  1'b0, 5'b11110};
    tbl[2] = '{4'd15, 4'd15, 1'b1, 5'b11110};
    tbl[3] = '{4'd0,  4'd0,  1'b0, 5'b00000};
    tbl[4] = '{4'd0,  4'd1,  1'b0, 5'b11111};
    tbl[5] = '{4'd15, 4'd1,  1'b1, 5'b10000};
    tbl[6] = '{4'd9,  4'd4,  1'b0, 5'b00101};
    tbl[7] = '{4'd7,  4'd8,  1'b1, 5'b01111};

    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = 1'b0;
    issue_en = 1'b1; res_ready = 1'b0;
    #1;
    chk("rst_in_ready", {15'd0, in_ready}, 16'd1);
    chk("rst_enable", {15'd0, enable}, 16'd0);
    chk("rst_res_valid", {15'd0, res_valid}, 16'd0);
    chk("rst_fifo_count", {13'd0, fifo_count}, 16'd0);
    chk("rst_res_data", {11'd0, res_data}, 16'd0);
    chk("rst_data_in_1", {12'd0, data_in_1}, 16'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Single commands: latency, pulse width and exact result values.
    for (int i = 0; i < 8; i++) begin
      push_cmd(tbl[i].a, tbl[i].b, tbl[i].op);
      step();
      chk("issue_enable", {15'd0, enable}, 16'd1);
      chk("issue_ctrl", {15'd0, ctrl}, {15'd0, tbl[i].op});
      chk("issue_d1", {12'd0, data_in_1}, {12'd0, tbl[i].a});
      chk("issue_d2", {12'd0, data_in_2}, {12'd0, tbl[i].b});
      step();
      chk("exec_enable_low", {15'd0, enable}, 16'd0);
      chk("exec_res_valid_low", {15'd0, res_valid}, 16'd0);
      step();
      chk("resp_valid", {15'd0, res_valid}, 16'd1);
      chk("resp_data", {11'd0, res_data}, {11'd0, tbl[i].res});
      chk("resp_op", {15'd0, res_op}, {15'd0, tbl[i].op});
      res_ready = 1'b1;
      step();
      chk("resp_accepted", {15'd0, res_valid}, 16'd0);
      res_ready = 1'b0;
    end

    // Back-to-back with res_ready high: enables every 3 cycles.
    res_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (i == 0)      begin in_valid = 1'b1; in_a = 4'd3;  in_b = 4'd5;  in_op = 1'b0; end
      else if (i == 1) begin in_valid = 1'b1; in_a = 4'd15; in_b = 4'd15; in_op = 1'b1; end
      else if (i == 2) begin in_valid = 1'b1; in_a = 4'd0;  in_b = 4'd0;  in_op = 1'b0; end
      else in_valid = 1'b0;
      step();
      if (enable) times.push_back(i);
    end
    chk("b2b_pulses", 16'(times.size()), 16'd3);
    if (times.size() == 3) begin
      chk("b2b_gap1", 16'(times[1] - times[0]), 16'd3);
      chk("b2b_gap2", 16'(times[2] - times[1]), 16'd3);
    end
    wait_drain(40);

    // Full FIFO with issue held off.
    issue_en = 1'b0;
    for (int j = 0; j < 4; j++) push_cmd(4'(j + 1), 4'(2 * j), 1'(j & 1));
    chk("full_count", {13'd0, fifo_count}, 16'd4);
    chk("full_in_ready", {15'd0, in_ready}, 16'd0);
    in_a = 4'd12; in_b = 4'd7; in_op = 1'b0; in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("full_hold_count", {13'd0, fifo_count}, 16'd4);
      chk("full_hold_enable", {15'd0, enable}, 16'd0);
    end
    issue_en = 1'b1;
    res_ready = 1'b1;
    push_cmd(4'd12, 4'd7, 1'b0);
    wait_drain(80);

    // Result backpressure with two commands queued behind a held result.
    push_cmd(4'd6, 4'd2, 1'b1);
    push_cmd(4'd1, 4'd9, 1'b0);
    push_cmd(4'd14, 4'd3, 1'b1);
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      if (res_valid) seen = 1'b1; else step();
    end
    chk("bp_res_valid", {15'd0, seen}, 16'd1);
    held_data = res_data;
    held_op = res_op;
    chk("bp_first_result", {10'd0, held_op, held_data}, {10'd0, 1'b1, 5'd8});
    for (int k = 0; k < 10; k++) begin
      step();
      chk("bp_valid_stable", {15'd0, res_valid}, 16'd1);
      chk("bp_data_stable", {10'd0, res_op, res_data}, {10'd0, held_op, held_data});
      chk("bp_no_enable", {15'd0, enable}, 16'd0);
    end
    chk("bp_queued", {13'd0, fifo_count}, 16'd2);
    res_ready = 1'b1;
    step();
    chk("bp_release_enable", {15'd0, enable}, 16'd1);
    chk("bp_release_valid", {15'd0, res_valid}, 16'd0);
    wait_drain(60);

    // Asynchronous reset during EXEC with two commands queued.
    issue_en = 1'b0;
    push_cmd(4'd2, 4'd2, 1'b1);
    push_cmd(4'd4, 4'd1, 1'b0);
    push_cmd(4'd8, 4'd8, 1'b1);
    issue_en = 1'b1;
    step();
    chk("rmid_exec", {15'd0, enable}, 16'd1);
    #2 rst = 1'b1;
    #1;
    chk("rmid_enable", {15'd0, enable}, 16'd0);
    chk("rmid_count", {13'd0, fifo_count}, 16'd0);
    chk("rmid_ctrl", {15'd0, ctrl}, 16'd0);
    chk("rmid_d1", {12'd0, data_in_1}, 16'd0);
    chk("rmid_in_ready", {15'd0, in_ready}, 16'd1);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    res_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step();
      chk("rpost_no_result", {15'd0, res_valid}, 16'd0);
      chk("rpost_no_enable", {15'd0, enable}, 16'd0);
    end
    res_ready = 1'b0;

    // Random stream through the FIFO with random backpressure.
    base = n_results;
    fork
      begin
        for (int j = 0; j < 12; j++)
          push_cmd(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
      end
      begin
        for (int k = 0; k < 600 && (n_results - base) < 12; k++) begin
          res_ready = 1'($urandom_range(0, 1));
          step();
        end
      end
    join
    chk("rand_result_count", 16'(n_results - base), 16'd12);
    wait_drain(40);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
